regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 73 +++++++
 tb/tb_regfile_sb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with a per-register pending (scoreboard) bit, optional same-cycle
// writeback forwarding and an optional hardwired-zero R0.
module regfile_sb #(
   parameter  int WIDTH   = 16,
   parameter  int NREGS   = 8,
   parameter  int ZERO_R0 = 0,
   parameter  int BYPASS  = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             LD_REG,
   input  logic [AW-1:0]    DR,
   input  logic [WIDTH-1:0] BUS,
   input  logic             ISSUE,
   input  logic [AW-1:0]    ISSUE_DR,
   input  logic [AW-1:0]    SR1,
   input  logic [AW-1:0]    SR2,
   input  logic             USE_SR1,
   input  logic             USE_SR2,
   output logic [WIDTH-1:0] SR1OUT,
   output logic [WIDTH-1:0] SR2OUT,
   output logic             HAZARD,
   output logic [NREGS-1:0] BUSY
);

   localparam bit ZR0 = (ZERO_R0 != 0);
   localparam bit BYP = (BYPASS != 0);

   logic [WIDTH-1:0] regs [NREGS];
   logic [NREGS-1:0] busy_nxt;
   logic             we;
   logic             fwd1, fwd2;

   assign we = LD_REG && !(ZR0 && (DR == '0));

   // Issue is applied after writeback so a simultaneous claim wins.
   always_comb begin
      busy_nxt = BUSY;
      if (LD_REG) busy_nxt[DR] = 1'b0;
      if (ISSUE) busy_nxt[ISSUE_DR] = 1'b1;
      if (ZR0) busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         BUSY <= '0;
      end else begin
         if (we) regs[DR] <= BUS;
         BUSY <= busy_nxt;
      end
   end

   assign fwd1 = BYP && LD_REG && (DR == SR1);
   assign fwd2 = BYP && LD_REG && (DR == SR2);

   always_comb begin
      SR1OUT = regs[SR1];
      if (fwd1) SR1OUT = BUS;
      if (ZR0 && (SR1 == '0)) SR1OUT = '0;
   end

   always_comb begin
      SR2OUT = regs[SR2];
      if (fwd2) SR2OUT = BUS;
      if (ZR0 && (SR2 == '0)) SR2OUT = '0;
   end

   assign HAZARD = (USE_SR1 && BUSY[SR1] && !fwd1) ||
                   (USE_SR2 && BUSY[SR2] && !fwd2);

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding and a non-forwarding instance share stimulus,
// a third instance covers the hardwired-zero R0 with a wider, deeper file.
module tb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic        ld, iss, u1, u2;
   logic [2:0]  dr, iss_dr, sr1, sr2;
   logic [15:0] bus;
   logic [15:0] a_sr1out, a_sr2out, b_sr1out, b_sr2out;
   logic        a_haz, b_haz;
   logic [7:0]  a_busy, b_busy;

   logic        c_ld, c_iss, c_u1, c_u2;
   logic [3:0]  c_dr, c_iss_dr, c_sr1, c_sr2;
   logic [31:0] c_bus, c_sr1out, c_sr2out;
   logic        c_haz;
   logic [15:0] c_busy;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0]  dr;
      logic [15:0] data;
   } wr_t;

   wr_t tbl [8];
   wr_t sb [$];
   wr_t e;

   regfile_sb #(.WIDTH(16), .NREGS(8), .ZERO_R0(0), .BYPASS(1)) dut_a (
      .Clk(clk), .Reset(rst_n), .LD_REG(ld), .DR(dr), .BUS(bus),
      .ISSUE(iss), .ISSUE_DR(iss_dr), .SR1(sr1), .SR2(sr2),
      .USE_SR1(u1), .USE_SR2(u2), .SR1OUT(a_sr1out), .SR2OUT(a_sr2out),
      .HAZARD(a_haz), .BUSY(a_busy));

   regfile_sb #(.WIDTH(16), .NREGS(8), .ZERO_R0(0), .BYPASS(0)) dut_b (
      .Clk(clk), .Reset(rst_n), .LD_REG(ld), .DR(dr), .BUS(bus),
      .ISSUE(iss), .ISSUE_DR(iss_dr), .SR1(sr1), .SR2(sr2),
      .USE_SR1(u1), .USE_SR2(u2), .SR1OUT(b_sr1out), .SR2OUT(b_sr2out),
      .HAZARD(b_haz), .BUSY(b_busy));

   regfile_sb #(.WIDTH(32), .NREGS(16), .ZERO_R0(1), .BYPASS(1)) dut_c (
      .Clk(clk), .Reset(rst_n), .LD_REG(c_ld), .DR(c_dr), .BUS(c_bus),
      .ISSUE(c_iss), .ISSUE_DR(c_iss_dr), .SR1(c_sr1), .SR2(c_sr2),
      .USE_SR1(c_u1), .USE_SR2(c_u2), .SR1OUT(c_sr1out), .SR2OUT(c_sr2out),
      .HAZARD(c_haz), .BUSY(c_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{3'd3, 16'hBEEF};
      tbl[1] = '{3'd0, 16'h1000};
      tbl[2] = '{3'd1, 16'h1111};
      tbl[3] = '{3'd2, 16'h2222};
      tbl[4] = '{3'd4, 16'h4444};
      tbl[5] = '{3'd5, 16'h5555};
      tbl[6] = '{3'd6, 16'h6666};
      tbl[7] = '{3'd7, 16'h7777};

      rst_n = 1'b0;
      ld = 0; iss = 0; u1 = 0; u2 = 0;
      dr = 0; iss_dr = 0; sr1 = 0; sr2 = 0; bus = 0;
      c_ld = 0; c_iss = 0; c_u1 = 0; c_u2 = 0;
      c_dr = 0; c_iss_dr = 0; c_sr1 = 0; c_sr2 = 0; c_bus = 0;
      #2;
      chk("reset_busy_a", a_busy, 8'h00);
      chk("reset_busy_c", c_busy, 16'h0000);
      chk("reset_sr1_a", a_sr1out, 16'h0000);
      chk("reset_haz_a", a_haz, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Write/read table: read each register the cycle after it is written.
      for (int i = 0; i <= 8; i++) begin
         cyc();
         if (i < 8) begin
            ld = 1; dr = tbl[i].dr; bus = tbl[i].data;
            sb.push_back(tbl[i]);
         end else begin
            ld = 0;
         end
         if (i > 0) begin
            e = sb.pop_front();
            sr1 = e.dr; sr2 = e.dr;
         end
         #3;
         if (i > 0) begin
            chk($sformatf("wr_rd_a1_r%0d", e.dr), a_sr1out, e.data);
            chk($sformatf("wr_rd_a2_r%0d", e.dr), a_sr2out, e.data);
            chk($sformatf("wr_rd_b1_r%0d", e.dr), b_sr1out, e.data);
            chk($sformatf("wr_rd_b2_r%0d", e.dr), b_sr2out, e.data);
         end
      end
      chk("busy_after_plain_wr_a", a_busy, 8'h00);
      chk("busy_after_plain_wr_b", b_busy, 8'h00);

      // Same-cycle forwarding
      cyc(); ld = 1; dr = 5; bus = 16'h1234; sr1 = 5; #3;
      chk("bypass_on_same", a_sr1out, 16'h1234);
      chk("bypass_off_same", b_sr1out, 16'h5555);
      cyc(); ld = 0; #3;
      chk("bypass_on_next", a_sr1out, 16'h1234);
      chk("bypass_off_next", b_sr1out, 16'h1234);

      // Hazard on a consumed source
      cyc(); iss = 1; iss_dr = 2; u2 = 1; sr2 = 2; #3;
      chk("haz_issue_cycle_a", a_haz, 1'b0);
      cyc(); iss = 0; #3;
      chk("haz_pending_a", a_haz, 1'b1);
      chk("haz_pending_b", b_haz, 1'b1);
      chk("busy2_set_a", a_busy, 8'h04);
      cyc(); #3;
      chk("haz_hold_b", b_haz, 1'b1);
      cyc(); ld = 1; dr = 2; bus = 16'hABCD; #3;
      chk("haz_wb_cycle_a", a_haz, 1'b0);
      chk("haz_wb_cycle_b", b_haz, 1'b1);
      chk("wb_fwd_sr2_a", a_sr2out, 16'hABCD);
      cyc(); ld = 0; #3;
      chk("haz_after_wb_a", a_haz, 1'b0);
      chk("haz_after_wb_b", b_haz, 1'b0);
      chk("wb_sr2_b", b_sr2out, 16'hABCD);
      chk("busy_clear_a", a_busy, 8'h00);

      // Unused source, double issue, single writeback clears
      cyc(); iss = 1; iss_dr = 2; u2 = 0; #3;
      cyc(); #3;
      chk("haz_unused_a", a_haz, 1'b0);
      chk("busy_double_issue_a", a_busy, 8'h04);
      cyc(); iss = 0; #3;
      chk("busy_hold_b", b_busy, 8'h04);
      chk("haz_unused_b", b_haz, 1'b0);
      cyc(); ld = 1; dr = 2; bus = 16'h2222;
      cyc(); ld = 0; #3;
      chk("busy_single_wb_a", a_busy, 8'h00);

      // Simultaneous issue and writeback to the same register
      cyc(); iss = 1; iss_dr = 6; ld = 1; dr = 6; bus = 16'h00AA;
      cyc(); iss = 0; ld = 0; sr1 = 6; #3;
      chk("simul_data_a", a_sr1out, 16'h00AA);
      chk("simul_data_b", b_sr1out, 16'h00AA);
      chk("simul_busy_a", a_busy, 8'h40);
      chk("simul_busy_b", b_busy, 8'h40);

      // Fill the scoreboard, then reset mid-stream
      for (int i = 0; i < 8; i++) begin
         cyc(); iss = 1; iss_dr = 3'(i);
      end
      cyc(); iss = 0; u1 = 1; sr1 = 3; #3;
      chk("busy_full_a", a_busy, 8'hFF);
      chk("busy_full_b", b_busy, 8'hFF);
      chk("haz_full_a", a_haz, 1'b1);
      rst_n = 1'b0; #1;
      chk("async_rst_busy_a", a_busy, 8'h00);
      chk("async_rst_busy_b", b_busy, 8'h00);
      chk("async_rst_haz_a", a_haz, 1'b0);
      chk("async_rst_haz_b", b_haz, 1'b0);
      for (int r = 0; r < 8; r++) begin
         sr1 = 3'(r); sr2 = 3'(r); #1;
         chk($sformatf("rst_rd_a_r%0d", r), a_sr1out, 16'h0000);
         chk($sformatf("rst_rd_b_r%0d", r), b_sr2out, 16'h0000);
      end
      ld = 1; dr = 3; bus = 16'h9999; sr1 = 3; iss = 1; iss_dr = 4; #1;
      chk("rst_fwd_a", a_sr1out, 16'h9999);
      chk("rst_fwd_b", b_sr1out, 16'h0000);
      cyc(); #3;
      chk("rst_issue_ignored_a", a_busy, 8'h00);
      iss = 0; u1 = 0; dr = 1; bus = 16'h0F0F;
      rst_n = 1'b1; #1;
      chk("rst_write_ignored_b", b_sr1out, 16'h0000);
      cyc(); ld = 0; sr1 = 1; #3;
      chk("first_write_a", a_sr1out, 16'h0F0F);
      chk("first_write_b", b_sr1out, 16'h0F0F);

      // Hardwired-zero R0 instance
      cyc(); c_ld = 1; c_dr = 0; c_bus = 32'hFFFFFFFF; c_iss = 1; c_iss_dr = 0;
      c_sr1 = 0; c_u1 = 1; #3;
      chk("r0_fwd_blocked_c", c_sr1out, 32'h0);
      cyc(); c_ld = 0; c_iss = 0; #3;
      chk("r0_read_c", c_sr1out, 32'h0);
      chk("r0_busy_c", c_busy, 16'h0000);
      chk("r0_haz_c", c_haz, 1'b0);
      cyc(); c_ld = 1; c_dr = 15; c_bus = 32'hDEADBEEF; c_iss = 1; c_iss_dr = 15;
      cyc(); c_ld = 0; c_iss = 0; c_sr1 = 15; c_sr2 = 15; #3;
      chk("r15_sr1_c", c_sr1out, 32'hDEADBEEF);
      chk("r15_sr2_c", c_sr2out, 32'hDEADBEEF);
      chk("r15_busy_c", c_busy, 16'h8000);
      chk("r15_haz_c", c_haz, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
